pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and target width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value after reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port stall, input, 1, hold PC when no redirect is present.
REQ-007 SHALL have port branch_taken, input, 1, relative redirect to PC + branch_offset.
REQ-008 SHALL have port branch_offset, input, XLEN, signed byte offset.
REQ-009 SHALL have port jump, input, 1, absolute redirect to jump_target.
REQ-010 SHALL have port jump_target, input, XLEN, absolute byte address.
REQ-011 SHALL have port call, input, 1, push PC+4 when the same-cycle jump or branch_taken redirect is taken.
REQ-012 SHALL have port ret, input, 1, redirect to the RAS top and pop it.
REQ-013 SHALL have port trap, input, 1, redirect to trap_vector and flush the RAS.
REQ-014 SHALL have port trap_vector, input, XLEN, trap handler address.
REQ-015 SHALL have port pc, output, XLEN, registered current PC.
REQ-016 SHALL have port ras_empty, output, 1, RAS count is 0.
REQ-017 SHALL have port ras_full, output, 1, RAS count equals RAS_DEPTH.
REQ-018 SHALL have port ras_overflow, output, 1, one-cycle pulse when a push overwrote the oldest entry.
REQ-019 SHALL have port ras_underflow, output, 1, one-cycle pulse when ret found the RAS empty.
REQ-020 SHALL have port misaligned, output, 1, one-cycle pulse when a loaded redirect target had nonzero bits [1:0].

Function
REQ-021 SHALL select the next PC by fixed priority: trap > ret > jump > branch_taken > stall > sequential (PC+4).
REQ-022 SHALL let any redirect override stall, so stall only holds PC when trap, ret, jump and branch_taken are all low.
REQ-023 SHALL compute all PC arithmetic modulo 2^XLEN, with wrap-around at the top of the address space and no saturation.
REQ-024 SHALL load every redirect target with bits [1:0] forced to 0, and assert misaligned for the following cycle if either original bit was 1.
REQ-025 SHALL update the PC one cycle after its inputs are sampled, with no combinational path from inputs to pc.
REQ-026 SHALL push only when call=1 and the winning source is jump or branch_taken; call is otherwise ignored.
REQ-027 SHALL push the value PC+4 of the cycle in which call is sampled.
REQ-028 SHALL implement the RAS as a circular LIFO with a top pointer and a count saturating at RAS_DEPTH.
REQ-029 SHALL, on a push while full, overwrite the oldest entry, keep the count at RAS_DEPTH and pulse ras_overflow.
REQ-030 SHALL, on ret while non-empty, load the top entry into the PC and decrement the count.
REQ-031 SHALL, on ret while empty, load PC+4, leave the RAS unchanged and pulse ras_underflow.
REQ-032 SHALL, on ret with call in the same cycle, pop only, with no push.
REQ-033 SHALL, on trap, set the RAS count to 0 and ignore same-cycle call and ret stack effects.
REQ-034 SHALL, on trap together with stall, load trap_vector.

Reset
REQ-035 SHALL, on rst=1 and asynchronously, set pc to RESET_VECTOR, set the RAS count and top pointer to 0, and set ras_overflow, ras_underflow and misaligned to 0.
REQ-036 SHALL drive ras_empty=1 and ras_full=0 during and immediately after reset.
REQ-037 SHALL abandon any redirect or push in flight at reset assertion, and SHALL NOT alter RAS entry contents through reset.
REQ-038 SHALL resume sequential fetch (RESET_VECTOR+4) on the first rising edge after rst deasserts with no other inputs active.

Verification
REQ-039 SHALL cover: reset, then 3 idle cycles -> pc = 0x0, 0x4, 0x8, 0xC.
REQ-040 SHALL cover: pc=0x100, stall=1 for 2 cycles with branch_taken=1 and offset=-0x10 on the second -> pc = 0x100, 0x100, 0xF0.
REQ-041 SHALL cover: pc=0x200, jump=1, call=1, target=0x800, then ret after 2 idle cycles -> pc = 0x800, 0x804, 0x808, 0x204; ras_empty=1 after the ret.
REQ-042 SHALL cover: 5 call-jumps at RAS_DEPTH=4 -> ras_overflow pulses on the 5th; 5 rets return the 4 newest addresses, then PC+4 with ras_underflow.
REQ-043 SHALL cover: pc=0xFFFFFFFC idle -> pc=0x0; jump target 0x1003 -> pc=0x1000 and misaligned pulses 1 cycle.
REQ-044 SHALL cover: trap, ret and jump together with trap_vector=0x80 -> pc=0x80, ras_empty=1; rst asserted mid-cycle -> pc=RESET_VECTOR immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with a small return-address stack.
//
// Picks the next PC by fixed priority: trap > ret > jump > branch_taken >
// stall > sequential (PC+4). The PC is registered, so inputs take effect
// one cycle after they are sampled. A call together with a winning jump or
// branch pushes PC+4 onto a circular RAS. When a push finds the RAS full,
// it overwrites the oldest entry.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   stall           hold PC when no redirect is requested
//   branch_taken    redirect to pc + branch_offset (signed)
//   jump            redirect to jump_target
//   call            push PC+4 when a jump or branch redirect wins
//   ret             redirect to RAS top and pop (PC+4 if the RAS is empty)
//   trap            redirect to trap_vector and flush the RAS
//   pc              registered current PC
//   ras_empty/full  RAS occupancy flags
//   ras_overflow    one-cycle pulse: a push overwrote the oldest entry
//   ras_underflow   one-cycle pulse: ret found the RAS empty
//   misaligned      one-cycle pulse: a loaded redirect target had bits [1:0] != 0
module pc_gen #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_offset,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] pc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_overflow,
  output logic            ras_underflow,
  output logic            misaligned
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   top;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_next;
  logic [PW-1:0]   top_inc;
  logic            redirect;
  logic            push;
  logic            pop;
  logic            underflow;

  assign pc_plus4  = pc + XLEN'(4);
  assign top_inc   = top + 1'b1;
  assign ras_empty = (count == '0);
  assign ras_full  = (count == DEPTH_C);

  always_comb begin
    redirect  = 1'b0;
    target    = '0;
    pc_next   = pc_plus4;
    push      = 1'b0;
    pop       = 1'b0;
    underflow = 1'b0;
    if (trap) begin
      redirect = 1'b1;
      target   = trap_vector;
    end else if (ret) begin
      redirect = 1'b1;
      if (!ras_empty) begin
        target = ras_mem[top];
        pop    = 1'b1;
      end else begin
        target    = pc_plus4;
        underflow = 1'b1;
      end
    end else if (jump) begin
      redirect = 1'b1;
      target   = jump_target;
      push     = call;
    end else if (branch_taken) begin
      redirect = 1'b1;
      target   = pc + branch_offset;
      push     = call;
    end else if (stall) begin
      pc_next = pc;
    end
    if (redirect)
      pc_next = {target[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_VECTOR;
      top           <= '0;
      count         <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      misaligned    <= 1'b0;
    end else begin
      pc            <= pc_next;
      ras_overflow  <= push && ras_full;
      ras_underflow <= underflow;
      misaligned    <= redirect && (target[1:0] != 2'b00);
      if (trap) begin
        count <= '0;
      end else if (pop) begin
        top   <= top - 1'b1;
        count <= count - CW'(1);
      end else if (push) begin
        top <= top_inc;
        if (!ras_full)
          count <= count + CW'(1);
      end
    end
  end

  // Entry storage has no reset so that reset leaves the contents untouched.
  // A push in flight while rst is high is dropped.
  always_ff @(posedge clk) begin
    if (push && !rst)
      ras_mem[top_inc] <= pc_plus4;
  end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic        call = 1'b0, ret = 1'b0, trap = 1'b0;
  logic [31:0] branch_offset = '0, jump_target = '0, trap_vector = '0;
  logic [31:0] pc;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow, misaligned;

  int total = 0;
  int bad   = 0;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .call(call), .ret(ret), .trap(trap), .trap_vector(trap_vector),
    .pc(pc), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0; trap = 0;
  endtask

  logic [31:0] ret_exp [4];

  initial begin
    // reset and sequential fetch
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_empty", {31'b0, ras_empty}, 1);
    check("rst_full", {31'b0, ras_full}, 0);
    step(); step();
    rst = 0;
    check("pc0", pc, 32'h0);
    step(); check("pc4", pc, 32'h4);
    step(); check("pc8", pc, 32'h8);
    step(); check("pcC", pc, 32'hC);

    // stall, then branch overriding stall
    jump = 1; jump_target = 32'h100;
    step(); check("jmp100", pc, 32'h100);
    check("jmp100_mis", {31'b0, misaligned}, 0);
    idle(); stall = 1;
    step(); check("stall1", pc, 32'h100);
    branch_taken = 1; branch_offset = -32'sd16;
    step(); check("br_over_stall", pc, 32'hF0);
    idle();

    // call / ret
    jump = 1; jump_target = 32'h200;
    step(); check("jmp200", pc, 32'h200);
    call = 1; jump_target = 32'h800;
    step(); check("call800", pc, 32'h800);
    check("call_nonempty", {31'b0, ras_empty}, 0);
    idle();
    step(); check("seq804", pc, 32'h804);
    step(); check("seq808", pc, 32'h808);
    ret = 1;
    step(); check("ret204", pc, 32'h204);
    check("ret_empty", {31'b0, ras_empty}, 1);
    idle();

    // five call-jumps at depth 4: pushes 0x208,0x1004,0x2004,0x3004,0x4004
    for (int i = 1; i <= 5; i++) begin
      jump = 1; call = 1; jump_target = 32'(i) << 12;
      step();
      check($sformatf("cj%0d_pc", i), pc, 32'(i) << 12);
      check($sformatf("cj%0d_ovf", i), {31'b0, ras_overflow}, (i == 5) ? 1 : 0);
    end
    check("full_after5", {31'b0, ras_full}, 1);
    idle();
    ret_exp[0] = 32'h4004; ret_exp[1] = 32'h3004;
    ret_exp[2] = 32'h2004; ret_exp[3] = 32'h1004;
    for (int i = 0; i < 4; i++) begin
      ret = 1;
      step();
      check($sformatf("ret%0d_pc", i), pc, ret_exp[i]);
      check($sformatf("ret%0d_unf", i), {31'b0, ras_underflow}, 0);
      check($sformatf("ret%0d_ovf", i), {31'b0, ras_overflow}, 0);
    end
    check("empty_after4", {31'b0, ras_empty}, 1);
    step(); check("ret_under_pc", pc, 32'h1008);
    check("ret_under_flag", {31'b0, ras_underflow}, 1);
    idle();
    step(); check("under_pulse_end", {31'b0, ras_underflow}, 0);
    check("after_under_pc", pc, 32'h100C);

    // wrap-around and misaligned target
    jump = 1; jump_target = 32'hFFFF_FFFC;
    step(); check("top_addr", pc, 32'hFFFF_FFFC);
    idle();
    step(); check("wrap0", pc, 32'h0);
    jump = 1; jump_target = 32'h1003;
    step(); check("mis_pc", pc, 32'h1000);
    check("mis_flag", {31'b0, misaligned}, 1);
    idle();
    step(); check("mis_pulse_end", {31'b0, misaligned}, 0);
    check("mis_next_pc", pc, 32'h1004);

    // trap beats ret/jump/call/stall and flushes RAS
    jump = 1; call = 1; jump_target = 32'h3000;
    step(); check("pre_trap_nonempty", {31'b0, ras_empty}, 0);
    trap = 1; ret = 1; jump = 1; call = 1; stall = 1;
    trap_vector = 32'h80; jump_target = 32'h500;
    step(); check("trap_pc", pc, 32'h80);
    check("trap_empty", {31'b0, ras_empty}, 1);
    check("trap_no_unf", {31'b0, ras_underflow}, 0);
    idle();
    step(); check("post_trap_pc", pc, 32'h84);

    // asynchronous reset mid-cycle
    #2 rst = 1;
    #1 check("async_rst_pc", pc, 32'h0);
    check("async_rst_empty", {31'b0, ras_empty}, 1);
    step();
    rst = 0;
    step(); check("resume_pc", pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
